serve_arbiter: RTL and testbench

SERVE_ARBITER -- requirements
Module: serve_arbiter

---
 rtl/serve_arbiter_if.sv | 34 +++
 rtl/serve_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_serve_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serve_arbiter_if.sv
// serve_arbiter_if -- request/serve/load bus between the pricing-module
// requesters, the serve arbiter and the data manager.
//
// Signals
//   req          requester -> arbiter  level request for a new data pack, one bit per requester
//   out_of_data  manager   -> arbiter  no buffered data; blocks the start of a new serve
//   reg_en       manager   -> arbiter  one-hot load strobe for the requester being loaded
//   serve_reg    arbiter   -> manager  one-hot serve request, held for the whole serve
//   grant_done   arbiter   -> requester one-cycle one-hot pulse once the pack is loaded
//   grant_id     arbiter   -> all      index of the current or last granted requester
//   busy         arbiter   -> all      high while a serve is outstanding
//
// Modports: slave is the arbiter side, master is the environment side.
interface serve_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic               out_of_data;
  logic [NUM_REQ-1:0] reg_en;
  logic [NUM_REQ-1:0] serve_reg;
  logic [NUM_REQ-1:0] grant_done;
  logic [3:0]         grant_id;
  logic               busy;

  modport slave (
    input  req, out_of_data, reg_en,
    output serve_reg, grant_done, grant_id, busy
  );

  modport master (
    output req, out_of_data, reg_en,
    input  serve_reg, grant_done, grant_id, busy
  );
endinterface

// File: rtl/serve_arbiter.sv
// serve_arbiter -- round-robin arbiter that hands the data manager one
// requester at a time and reports completion back to that requester.
//
// Ports
//   clock         sole clock, rising edge
//   reset         synchronous, active-low
//   bus           serve_arbiter_if.slave (req, out_of_data, reg_en in;
//                 serve_reg, grant_done, grant_id, busy out)
//   served_count  completed serves, wraps 0xFFFF -> 0x0000
//   err_mismatch  sticky: reg_en seen for a requester that is not granted
//   err_timeout   sticky: a serve was aborted by the timeout (0 when the
//                 timeout feature is not built)
//   dbgState      current FSM state (0 IDLE, 1 SERVE, 2 DONE)
//
// Handshake: a requester holds req high until it sees its grant_done pulse.
// The arbiter holds serve_reg one-hot for the whole serve; the data manager
// answers with a single reg_en strobe on the same bit, which completes the
// serve. grant_done then pulses for one cycle and serve_reg drops. Only
// reg_en bits seen while a serve is outstanding have any effect.
//
// Optional feature: define SERVE_ARB_TIMEOUT_EN to abort a serve after
// TIMEOUT_CYCLES cycles without the matching reg_en.
module serve_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  serve_arbiter_if.slave bus,
  output logic [15:0] served_count,
  output logic        err_mismatch,
  output logic        err_timeout,
  output logic [1:0]  dbgState
);

  if (NUM_REQ < 1 || NUM_REQ > 16) begin : gBadNumReq
    $error("serve_arbiter: NUM_REQ must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
    $error("serve_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic [3:0]           ptr;
  logic [3:0]           grantId;
  logic [15:0]          servedCount;
  logic                 errMismatch;

  logic [2*NUM_REQ-1:0] reqDouble;
  logic [2*NUM_REQ-1:0] reqShift;
  logic [4:0]           offset;
  logic                 found;
  logic [4:0]           winnerSum;
  logic [4:0]           winner;
  logic [4:0]           ptrInc;
  logic [4:0]           ptrAfter;
  logic [NUM_REQ-1:0]   grantOneHot;
  logic                 regEnHit;
  logic                 regEnStray;
  logic                 startServe;
  logic                 timeoutHit;

  // Round-robin pick: rotate req right by ptr so that bit 0 of the rotated
  // vector is requester ptr, take the lowest set bit, then rotate back.
  // ptr is always below NUM_REQ, so the doubled vector covers the wrap.
  always_comb begin
    reqDouble = {bus.req, bus.req};
    reqShift  = reqDouble >> ptr;
    offset    = 5'd0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && reqShift[i]) begin
        found  = 1'b1;
        offset = 5'(i);
      end
    end
    winnerSum = {1'b0, ptr} + offset;
    winner    = (winnerSum >= 5'(NUM_REQ)) ? (winnerSum - 5'(NUM_REQ)) : winnerSum;
  end

  // Pointer value after a serve ends (completed or aborted).
  always_comb begin
    ptrInc   = {1'b0, grantId} + 5'd1;
    ptrAfter = (ptrInc >= 5'(NUM_REQ)) ? 5'd0 : ptrInc;
  end

  always_comb begin
    grantOneHot = NUM_REQ'(1) << grantId;
    regEnHit    = |(bus.reg_en & grantOneHot);
    regEnStray  = |(bus.reg_en & ~grantOneHot);
  end

  // Next-state logic.
  always_comb begin
    stateNext  = state;
    startServe = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.out_of_data && (|bus.req)) begin
          stateNext  = SERVE;
          startServe = 1'b1;
        end
      end
      SERVE: begin
        // A matching strobe wins over a timeout landing in the same cycle.
        if (regEnHit) begin
          stateNext = DONE;
        end else if (timeoutHit) begin
          stateNext = IDLE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state, so they change only
  // after a clock edge.
  always_comb begin
    bus.serve_reg  = (state == SERVE) ? grantOneHot : '0;
    bus.grant_done = (state == DONE)  ? grantOneHot : '0;
    bus.busy       = (state == SERVE);
    bus.grant_id   = grantId;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= 4'd0;
      grantId     <= 4'd0;
      servedCount <= 16'd0;
      errMismatch <= 1'b0;
    end else begin
      state <= stateNext;
      if (startServe) begin
        grantId <= winner[3:0];
      end
      if ((state == SERVE) && regEnStray) begin
        errMismatch <= 1'b1;
      end
      if (state == DONE) begin
        servedCount <= servedCount + 16'd1;
        ptr         <= ptrAfter[3:0];
      end
      if (timeoutHit) begin
        ptr <= ptrAfter[3:0];
      end
    end
  end

`ifdef SERVE_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] toCount;
  logic        errTimeout;

  // toCount holds the number of SERVE cycles already spent, so the serve
  // is dropped at the end of its TIMEOUT_CYCLES-th cycle.
  assign timeoutHit = (state == SERVE) && !regEnHit && (toCount == TimeoutLast);

  always_ff @(posedge clock) begin
    if (!reset) begin
      toCount    <= 16'd0;
      errTimeout <= 1'b0;
    end else begin
      if (startServe) begin
        toCount <= 16'd0;
      end else if (state == SERVE) begin
        toCount <= toCount + 16'd1;
      end
      if (timeoutHit) begin
        errTimeout <= 1'b1;
      end
    end
  end

  assign err_timeout = errTimeout;
`else
  assign timeoutHit  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign served_count = servedCount;
  assign err_mismatch = errMismatch;
  assign dbgState     = state;

endmodule

// File: tb/tb_serve_arbiter.sv
// tb_serve_arbiter -- self-checking bench for serve_arbiter.
// Expected grants come from a transaction-level round-robin model (pointer
// plus modulo search), expected completions from a queue of one-hot grants.
module tb_serve_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  serve_arbiter_if #(.NUM_REQ(N)) bus ();

  logic [15:0] served_count;
  logic        err_mismatch;
  logic        err_timeout;
  logic [1:0]  dbg_state;

  serve_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .served_count (served_count),
    .err_mismatch (err_mismatch),
    .err_timeout  (err_timeout),
    .dbgState     (dbg_state)
  );

  // ---------------- reference model ----------------
  int          checks   = 0;
  int          failures = 0;
  int          exp_ptr;
  logic [15:0] exp_count;
  logic        exp_mismatch;
  logic        exp_timeout;
  logic [N-1:0] exp_q[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] one_hot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0 && idx < N) v[idx] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    exp_ptr      = 0;
    exp_count    = 16'd0;
    exp_mismatch = 1'b0;
    exp_timeout  = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_reset;
    reset           = 1'b0;
    bus.req         = '0;
    bus.reg_en      = '0;
    bus.out_of_data = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    model_reset();
  endtask

  // One full serve from IDLE: request, hold, load strobe, completion.
  task automatic run_serve(input logic [N-1:0] r, input int hold,
                           input logic [N-1:0] stray, input bit ood_mid,
                           input bit scramble);
    int           w;
    logic [N-1:0] oh;
    logic [N-1:0] extra;
    bus.req = r;
    w  = rr_pick(r, exp_ptr);
    oh = one_hot(w);
    extra = stray & ~oh;
    exp_q.push_back(oh);
    tick;
    checks++;
    if (bus.serve_reg !== oh || bus.busy !== 1'b1 || bus.grant_id !== 4'(w)) begin
      failures++;
      $display("FAIL serve_start: serve_reg=%b busy=%b grant_id=%0d expected serve_reg=%b busy=1 grant_id=%0d",
               bus.serve_reg, bus.busy, bus.grant_id, oh, w);
    end
    if (ood_mid) bus.out_of_data = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (scramble) bus.req = N'($urandom);
      tick;
      checks++;
      if (bus.serve_reg !== oh || bus.busy !== 1'b1 || bus.grant_done !== '0) begin
        failures++;
        $display("FAIL serve_hold: serve_reg=%b busy=%b grant_done=%b expected serve_reg=%b busy=1 grant_done=0",
                 bus.serve_reg, bus.busy, bus.grant_done, oh);
      end
    end
    bus.reg_en = oh | extra;
    if (extra != '0) exp_mismatch = 1'b1;
    tick;
    bus.reg_en      = '0;
    bus.out_of_data = 1'b0;
    checks++;
    if (exp_q.size() == 0 || bus.grant_done !== exp_q[0] || bus.serve_reg !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL grant_done: grant_done=%b serve_reg=%b busy=%b expected grant_done=%b serve_reg=0 busy=0",
               bus.grant_done, bus.serve_reg, bus.busy, oh);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_count = exp_count + 16'd1;
    exp_ptr   = (w + 1) % N;
    tick;
    checks++;
    if (bus.grant_done !== '0 || served_count !== exp_count ||
        err_mismatch !== exp_mismatch || err_timeout !== exp_timeout) begin
      failures++;
      $display("FAIL post_serve: grant_done=%b served_count=%0d err_mismatch=%b err_timeout=%b expected 0 %0d %b %b",
               bus.grant_done, served_count, err_mismatch, err_timeout, exp_count, exp_mismatch, exp_timeout);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset           = 1'b0;
    bus.req         = '1;
    bus.reg_en      = '1;
    bus.out_of_data = 1'b0;
    tick;
    tick;
    checks++;
    if (bus.serve_reg !== '0 || bus.grant_done !== '0 || bus.busy !== 1'b0 || bus.grant_id !== 4'd0 ||
        served_count !== 16'd0 || err_mismatch !== 1'b0 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: serve_reg=%b grant_done=%b busy=%b grant_id=%0d count=%0d errm=%b errt=%b expected all zero",
               bus.serve_reg, bus.grant_done, bus.busy, bus.grant_id, served_count, err_mismatch, err_timeout);
    end
    bus.req    = '0;
    bus.reg_en = '0;
    reset      = 1'b1;
    model_reset();
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.serve_reg !== '0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b serve_reg=%b expected 0 0", bus.busy, bus.serve_reg);
    end
  endtask

  task automatic test_alternate;
    int seq[4] = '{0, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      run_serve(4'b0101, 6, '0, 1'b0, 1'b0);
      checks++;
      if (bus.grant_id !== 4'(seq[i])) begin
        failures++;
        $display("FAIL alternate_order: serve %0d grant_id=%0d expected %0d", i, bus.grant_id, seq[i]);
      end
    end
    bus.req = '0;
    checks++;
    if (served_count !== 16'd4) begin
      failures++;
      $display("FAIL alternate_count: served_count=%0d expected 4", served_count);
    end
  endtask

  task automatic test_idle_reg_en;
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      bus.reg_en = N'($urandom_range(1, (1 << N) - 1));
      tick;
      checks++;
      if (bus.busy !== 1'b0 || bus.grant_done !== '0 || err_mismatch !== exp_mismatch ||
          served_count !== exp_count) begin
        failures++;
        $display("FAIL idle_reg_en: busy=%b grant_done=%b err_mismatch=%b count=%0d expected 0 0 %b %0d",
                 bus.busy, bus.grant_done, err_mismatch, served_count, exp_mismatch, exp_count);
      end
    end
    bus.reg_en = '0;
  endtask

  task automatic test_wrap;
    apply_reset();
    run_serve(4'b1000, 2, '0, 1'b0, 1'b0);
    bus.req = '0;
    checks++;
    if (bus.grant_id !== 4'd3) begin
      failures++;
      $display("FAIL wrap_first: grant_id=%0d expected 3", bus.grant_id);
    end
    run_serve(4'b1001, 2, '0, 1'b0, 1'b0);
    bus.req = '0;
    checks++;
    if (bus.grant_id !== 4'd0) begin
      failures++;
      $display("FAIL wrap_second: grant_id=%0d expected 0", bus.grant_id);
    end
  endtask

  task automatic test_out_of_data;
    int bad;
    bad = 0;
    bus.out_of_data = 1'b1;
    bus.req         = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.serve_reg !== '0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL out_of_data_block: %0d cycles with serve_reg or busy set, expected 0", bad);
    end
    bus.out_of_data = 1'b0;
    run_serve(4'b0001, 1, '0, 1'b0, 1'b0);
    bus.req = '0;
  endtask

  task automatic test_mismatch;
    bus.req = 4'b0010;
    tick;
    checks++;
    if (bus.serve_reg !== 4'b0010) begin
      failures++;
      $display("FAIL mismatch_grant: serve_reg=%b expected 0010", bus.serve_reg);
    end
    bus.reg_en = 4'b0100;
    tick;
    bus.reg_en   = '0;
    exp_mismatch = 1'b1;
    checks++;
    if (err_mismatch !== 1'b1 || bus.serve_reg !== 4'b0010 || bus.busy !== 1'b1 || bus.grant_done !== '0) begin
      failures++;
      $display("FAIL mismatch_flag: err_mismatch=%b serve_reg=%b busy=%b grant_done=%b expected 1 0010 1 0000",
               err_mismatch, bus.serve_reg, bus.busy, bus.grant_done);
    end
    tick;
    bus.reg_en = 4'b0010;
    tick;
    bus.reg_en = '0;
    bus.req    = '0;
    checks++;
    if (bus.grant_done !== 4'b0010) begin
      failures++;
      $display("FAIL mismatch_done: grant_done=%b expected 0010", bus.grant_done);
    end
    exp_count = exp_count + 16'd1;
    exp_ptr   = 2;
    tick;
    checks++;
    if (served_count !== exp_count || err_mismatch !== 1'b1) begin
      failures++;
      $display("FAIL mismatch_after: served_count=%0d err_mismatch=%b expected %0d 1",
               served_count, err_mismatch, exp_count);
    end
  endtask

`ifdef SERVE_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int           w;
    logic [N-1:0] oh;
    int           bad;
    bad = 0;
    bus.req = 4'b1111;
    w  = rr_pick(4'b1111, exp_ptr);
    oh = one_hot(w);
    tick;
    if (bus.serve_reg !== oh) bad++;
    for (int i = 1; i < TO; i++) begin
      tick;
      if (bus.serve_reg !== oh || bus.busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL timeout_hold: %0d cycles without serve_reg=%b in the first %0d serve cycles", bad, oh, TO);
    end
    tick;
    exp_timeout = 1'b1;
    exp_ptr     = (w + 1) % N;
    checks++;
    if (err_timeout !== 1'b1 || bus.serve_reg !== '0 || bus.grant_done !== '0 || served_count !== exp_count) begin
      failures++;
      $display("FAIL timeout_abort: err_timeout=%b serve_reg=%b grant_done=%b count=%0d expected 1 0 0 %0d",
               err_timeout, bus.serve_reg, bus.grant_done, served_count, exp_count);
    end
    run_serve(4'b1111, 1, '0, 1'b0, 1'b0);
    bus.req = '0;
  endtask
`else
  task automatic test_no_timeout;
    run_serve(4'b0100, 12 * TO, '0, 1'b0, 1'b0);
    bus.req = '0;
  endtask
`endif

  task automatic test_reset_mid_serve;
    bus.req = N'($urandom_range(1, (1 << N) - 1));
    tick;
    tick;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy: busy=%b expected 1", bus.busy);
    end
    reset      = 1'b0;
    bus.reg_en = bus.serve_reg;
    tick;
    checks++;
    if (bus.serve_reg !== '0 || bus.grant_done !== '0 || bus.busy !== 1'b0 || bus.grant_id !== 4'd0 ||
        served_count !== 16'd0 || err_mismatch !== 1'b0 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL midreset_values: serve_reg=%b grant_done=%b busy=%b grant_id=%0d count=%0d errm=%b errt=%b expected all zero",
               bus.serve_reg, bus.grant_done, bus.busy, bus.grant_id, served_count, err_mismatch, err_timeout);
    end
    reset      = 1'b1;
    bus.reg_en = '0;
    bus.req    = '0;
    model_reset();
    tick;
    checks++;
    if (bus.grant_done !== '0 || served_count !== 16'd0) begin
      failures++;
      $display("FAIL midreset_nodone: grant_done=%b served_count=%0d expected 0 0", bus.grant_done, served_count);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] r;
    logic [N-1:0] stray;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.req = '0;
        tick;
        checks++;
        if (bus.busy !== 1'b0 || bus.serve_reg !== '0) begin
          failures++;
          $display("FAIL random_idle: busy=%b serve_reg=%b expected 0 0", bus.busy, bus.serve_reg);
        end
      end
      r     = N'($urandom_range(1, (1 << N) - 1));
      stray = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      run_serve(r, $urandom_range(0, 4), stray, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.req = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req         = '0;
    bus.reg_en      = '0;
    bus.out_of_data = 1'b0;
    model_reset();
    test_reset();
    test_alternate();
    test_idle_reg_en();
    test_wrap();
    test_out_of_data();
    test_mismatch();
`ifdef SERVE_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_serve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
